// File: rtl/matrix_controller_pkg.sv
// Shared constants and types for the matrix_controller lane scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_controller_pkg;

  localparam int LANE_WIDTH = 32;
  localparam int NUM_LANES  = 3;
  // Three 32-bit lanes summed zero-extended never exceed 34 bits.
  localparam int SUM_WIDTH  = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Snapshot of the input bus; element 0 is x[31:0].
  typedef logic [NUM_LANES-1:0][LANE_WIDTH-1:0] lanes_t;

endpackage

// File: rtl/matrix_lane_mux.sv
// Selects one 32-bit lane of the frame snapshot by lane index.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   lanes - snapshot of all three lanes
//   sel   - lane index; 3 selects nothing and yields 0
//   lane  - selected lane
module matrix_lane_mux
  import matrix_controller_pkg::*;
(
  input  lanes_t                  lanes,
  input  logic [1:0]              sel,
  output logic [LANE_WIDTH-1:0]   lane
);

  always_comb begin
    lane = '0;
    case (sel)
      2'd0:    lane = lanes[0];
      2'd1:    lane = lanes[1];
      2'd2:    lane = lanes[2];
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/matrix_controller.sv
// Free-running frame scanner: snapshots x, emits J_MAX lanes, pulses frame_done, reports the lane sum.
// Latency: first lane_valid 2 cycles after reset release; frame period J_MAX+2 cycles.
// Backpressure: none; outputs stream unconditionally.
//
// Ports:
//   clock, reset_n - single clock, asynchronous active-low reset
//   x              - three packed 32-bit lanes, sampled only in LOAD
//   lane, j_idx    - emitted lane and its index (0 outside SCAN)
//   lane_valid     - high during SCAN cycles
//   frame_done     - one-cycle pulse in DONE
//   sum            - sum of the last completed frame's lanes
// Optional feature: define MATRIX_CONTROLLER_SUM_EN to build the accumulator;
// otherwise sum is tied to 0.
module matrix_controller
  import matrix_controller_pkg::*;
#(
  parameter int J_MAX  = 3,
  parameter int LANE_W = 32
)(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3*LANE_W-1:0]   x,
  output logic [LANE_W-1:0]     lane,
  output logic [1:0]            j_idx,
  output logic                  lane_valid,
  output logic                  frame_done,
  output logic [SUM_WIDTH-1:0]  sum
);

  if (J_MAX < 1 || J_MAX > NUM_LANES) begin : g_bad_j_max
    $error("matrix_controller: J_MAX must be in 1..3");
  end
  if (LANE_W != LANE_WIDTH) begin : g_bad_lane_w
    $error("matrix_controller: LANE_W must be 32");
  end

  localparam logic [1:0] J_LAST = 2'(J_MAX - 1);

  state_t                 state_q, state_d;
  logic [1:0]             j_q, j_d;
  lanes_t                 snapshot_q;
  logic [LANE_WIDTH-1:0]  mux_lane;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    lane_valid = 1'b0;
    frame_done = 1'b0;
    lane       = '0;
    j_idx      = '0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        state_d = SCAN;
        j_d     = '0;
      end
      SCAN: begin
        lane_valid = 1'b1;
        lane       = mux_lane;
        j_idx      = j_q;
        if (j_q == J_LAST) begin
          state_d = DONE;
          j_d     = '0;
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // x is only looked at here, so mid-frame changes wait for the next LOAD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snapshot_q <= '0;
    end else if (state_q == LOAD) begin
      snapshot_q <= x;
    end
  end

  matrix_lane_mux u_lane_mux (
    .lanes (snapshot_q),
    .sel   (j_q),
    .lane  (mux_lane)
  );

`ifdef MATRIX_CONTROLLER_SUM_EN
  logic [SUM_WIDTH-1:0] acc_q;
  logic [SUM_WIDTH-1:0] sum_q;

  // Accumulator is complete during DONE; sum becomes visible the cycle after.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      case (state_q)
        LOAD: acc_q <= '0;
        SCAN: acc_q <= acc_q + {{(SUM_WIDTH-LANE_WIDTH){1'b0}}, mux_lane};
        DONE: sum_q <= acc_q;
        default: ;
      endcase
    end
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule

// File: tb/tb_matrix_controller.sv
// Randomized bench for matrix_controller: J_MAX=3 and J_MAX=1 instances against a frame-position model.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_controller;

`ifdef MATRIX_CONTROLLER_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [95:0] x3, x1;
  logic [31:0] lane3, lane1;
  logic [1:0]  jidx3, jidx1;
  logic        v3, v1, fd3, fd1;
  logic [33:0] sum3, sum1;

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // rising edges since reset release
  int mode     = 0;

  logic [95:0] snap3 = '0, snap1 = '0;
  logic [33:0] msum3 = '0, msum1 = '0;

  always #5 clock = ~clock;

  matrix_controller #(.J_MAX(3), .LANE_W(32)) dut3 (
    .clock(clock), .reset_n(reset_n), .x(x3),
    .lane(lane3), .j_idx(jidx3), .lane_valid(v3),
    .frame_done(fd3), .sum(sum3)
  );

  matrix_controller #(.J_MAX(1), .LANE_W(32)) dut1 (
    .clock(clock), .reset_n(reset_n), .x(x1),
    .lane(lane1), .j_idx(jidx1), .lane_valid(v1),
    .frame_done(fd1), .sum(sum1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s n=%0d: got %0h want %0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input logic [95:0] s, input int k);
    logic [95:0] t;
    t = s >> (32 * k);
    return t[31:0];
  endfunction

  function automatic logic [33:0] lanesum(input logic [95:0] s, input int jm);
    logic [33:0] acc;
    acc = '0;
    for (int k = 0; k < jm; k++) acc = acc + {2'b00, lane_of(s, k)};
    return acc;
  endfunction

  // Position in frame: 0 = LOAD, 1..J = SCAN lane p-1, J+1 = DONE.
  task automatic check_dut(input int jm, input string nm,
                           input logic [31:0] o_lane, input logic [1:0] o_j,
                           input logic o_v, input logic o_fd, input logic [33:0] o_sum,
                           input logic [95:0] snap, input logic [33:0] msum);
    int          p;
    logic        ev, efd;
    logic [31:0] el;
    logic [1:0]  ej;
    p   = (n - 1) % (jm + 2);
    ev  = (p >= 1) && (p <= jm);
    efd = (p == jm + 1);
    el  = ev ? lane_of(snap, p - 1) : 32'd0;
    ej  = ev ? 2'(p - 1) : 2'd0;
    chk({nm, "_valid"}, 64'(o_v), 64'(ev));
    chk({nm, "_lane"},  64'(o_lane), 64'(el));
    chk({nm, "_jidx"},  64'(o_j), 64'(ej));
    chk({nm, "_done"},  64'(o_fd), 64'(efd));
    chk({nm, "_sum"},   64'(o_sum), SUM_EN ? 64'(msum) : 64'd0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_v3"},   64'(v3), 64'd0);
    chk({nm, "_l3"},   64'(lane3), 64'd0);
    chk({nm, "_j3"},   64'(jidx3), 64'd0);
    chk({nm, "_fd3"},  64'(fd3), 64'd0);
    chk({nm, "_s3"},   64'(sum3), 64'd0);
    chk({nm, "_v1"},   64'(v1), 64'd0);
    chk({nm, "_l1"},   64'(lane1), 64'd0);
    chk({nm, "_fd1"},  64'(fd1), 64'd0);
    chk({nm, "_s1"},   64'(sum1), 64'd0);
  endtask

  task automatic drive();
    case (mode)
      0: begin
        x3 = 96'h1;
        x1 = {32'd9, 32'd7, 32'd5};
      end
      1: begin
        x3 = {3{32'hFFFF_FFFF}};
        x1 = {32'd9, 32'd7, 32'd5};
      end
      default: begin
        if ($urandom_range(0, 1) == 1) x3 = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) x1 = {$urandom, $urandom, $urandom};
      end
    endcase
  endtask

  task automatic step();
    int p3, p1;
    @(posedge clock);
    n++;
    @(negedge clock);
    check_dut(3, "j3", lane3, jidx3, v3, fd3, sum3, snap3, msum3);
    check_dut(1, "j1", lane1, jidx1, v1, fd1, sum1, snap1, msum1);
    drive();
    // The value on x at the edge that ends LOAD is the frame's snapshot.
    p3 = (n - 1) % 5;
    p1 = (n - 1) % 3;
    if (p3 == 0) snap3 = x3;
    if (p3 == 4) msum3 = lanesum(snap3, 3);
    if (p1 == 0) snap1 = x1;
    if (p1 == 2) msum1 = lanesum(snap1, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    x3 = 96'h1;
    x1 = {32'd9, 32'd7, 32'd5};
    repeat (3) @(negedge clock);
    check_reset("rst");

    reset_n = 1'b1;
    n = 0;
    mode = 0;
    repeat (10) step();
    mode = 1;
    repeat (15) step();
    mode = 2;
    repeat (60) step();

    // Abort a frame while the J_MAX=3 instance is emitting lane 1.
    for (int i = 0; i < 10; i++) begin
      if ((n - 1) % 5 == 2) break;
      step();
    end
    chk("pre_abort_j", 64'(jidx3), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clock);
    check_reset("abort_hold");
    reset_n = 1'b1;
    n = 0;
    msum3 = '0;
    msum1 = '0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
